// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the HI/LO multiply/divide unit.
//   - 4-bit operation codes presented on the unit's op input
//   - FSM state encoding used by md_unit_param
//   - divider iteration count helper (one quotient bit per step)
package md_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL      = 2'd1,
        DIV_ITER = 2'd2,
        DIV_FIX  = 2'd3
    } md_state_e;

    // Restoring division retires one quotient bit per step.
    function automatic int md_div_iters(input int width);
        return width;
    endfunction

endpackage

// File: rtl/md_divider.sv
// md_divider: iterative restoring divider with sign fix-up.
//   clk, rst_ni      : clock, asynchronous active-low reset
//   start_i          : load operands and begin WIDTH restoring steps
//   flush_i          : abandon the division in progress
//   signed_i         : 1 = DIV (two's complement), 0 = DIVU
//   a_i, b_i         : dividend, divisor
//   last_o           : high in the cycle whose edge performs the final step
//   quo_o, rem_o     : sign-corrected quotient/remainder, valid after last step
// Divide by zero yields quo = all ones and rem = dividend (no early exit).
module md_divider
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int ITERS = md_div_iters(WIDTH);
    localparam int CNT_W = $clog2(ITERS + 1);

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q;
    logic             qneg_q, rneg_q, dz_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    // One restoring step: shift in next dividend bit, trial subtract.
    // The quotient register doubles as the dividend shift register.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
        if (!diff[WIDTH+1]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (flush_i) begin
            run_q <= 1'b0;
        end else if (start_i) begin
            run_q  <= 1'b1;
            cnt_q  <= CNT_W'(ITERS);
            rem_q  <= '0;
            quo_q  <= mag(a_i, signed_i);
            dvs_q  <= mag(b_i, signed_i);
            qneg_q <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_q <= signed_i & a_i[WIDTH-1];
            dz_q   <= (b_i == '0);
        end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) run_q <= 1'b0;
        end
    end

    assign last_o = run_q && (cnt_q == CNT_W'(1));
    // Remainder follows the dividend sign; with a zero divisor the
    // remainder magnitude is |a|, so this restores a exactly.
    // MIN / -1 needs no special case: negating 2^(WIDTH-1) wraps to MIN.
    assign quo_o  = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
    assign rem_o  = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/md_unit_param.sv
// md_unit_param: parametrised HI/LO multiply/divide unit (EX stage).
//   clk, reset  : clock, asynchronous active-low reset
//   start, op   : launch op (sampled only when idle); op codes from md_pkg
//   a, b        : operands (a is also the MTHI/MTLO source)
//   flush       : abort in-flight op, HI/LO untouched, no done
//   busy        : op in flight
//   done        : one-cycle pulse in the cycle after HI/LO commit
//   hi, lo      : architectural HI/LO
//   out         : hi for MFHI, lo for MFLO, else 0 (combinational)
// Optional feature macro MD_MADD_EN: accepts MADD/MADDU/MSUB/MSUBU
// (accumulate into {hi,lo} at commit); undefined, they are ignored.
module md_unit_param
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);

    localparam int CNT_W = $clog2(MULT_LAT + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, commit;

    logic               is_mul, is_div, mul_signed, div_start;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod_full, mul_res;
    logic               div_last;
    logic [WIDTH-1:0]   div_quo, div_rem;

`ifdef MD_MADD_EN
    logic acc_q, acc_d, sub_q, sub_d, is_acc, is_sub;
    assign is_acc = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    assign is_sub = (op == OP_MSUB) || (op == OP_MSUBU);
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU) || is_acc;
    assign mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
`else
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign mul_signed = (op == OP_MULT);
`endif
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);

    // Extending to 2*WIDTH first makes a modulo-2^(2W) multiply give the
    // exact signed or unsigned full product.
    assign a_ext     = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign b_ext     = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign prod_full = a_ext * b_ext;

    assign div_start = (state_q == IDLE) && start && !flush && is_div;

    md_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst_ni   (reset),
        .start_i  (div_start),
        .flush_i  (flush),
        .signed_i (op == OP_DIV),
        .a_i      (a),
        .b_i      (b),
        .last_o   (div_last),
        .quo_o    (div_quo),
        .rem_o    (div_rem)
    );

    always_comb begin
`ifdef MD_MADD_EN
        if (!acc_q)     mul_res = prod_q;
        else if (sub_q) mul_res = {hi_q, lo_q} - prod_q;
        else            mul_res = {hi_q, lo_q} + prod_q;
`else
        mul_res = prod_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        commit  = 1'b0;
`ifdef MD_MADD_EN
        acc_d   = acc_q;
        sub_d   = sub_q;
`endif
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            state_d = MUL;
                            cnt_d   = CNT_W'(MULT_LAT);
                            prod_d  = prod_full;
`ifdef MD_MADD_EN
                            acc_d   = is_acc;
                            sub_d   = is_sub;
`endif
                        end else if (is_div) begin
                            state_d = DIV_ITER;
                        end
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
                MUL: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        commit       = 1'b1;
                        state_d      = IDLE;
                        {hi_d, lo_d} = mul_res;
                    end
                end
                DIV_ITER: begin
                    if (div_last) state_d = DIV_FIX;
                end
                DIV_FIX: begin
                    commit  = 1'b1;
                    state_d = IDLE;
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MD_MADD_EN
            acc_q   <= 1'b0;
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= commit;
`ifdef MD_MADD_EN
            acc_q   <= acc_d;
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign out  = (op == OP_MFHI) ? hi_q : ((op == OP_MFLO) ? lo_q : '0);

endmodule

// File: tb/tb_md_unit_param.sv
module tb_md_unit_param;

    localparam int W = 32;

    logic         clk, reset, start, flush;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo, out;

    int n_checks = 0;
    int n_errors = 0;

    md_unit_param #(.WIDTH(W), .MULT_LAT(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch an op and wait (bounded) for busy to drop; counts done pulses
    // seen up to and including the cycle after the commit.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          output int lat, output int dones);
        op = o; a = va; b = vb; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; dones = 0;
        while (busy && lat < 100) begin
            tick();
            lat++;
            if (done) dones++;
        end
        tick();
        if (done) dones++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks += 4;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %h want 0", busy); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %h want 0", done); end
        if (hi !== '0) begin n_errors++; $display("FAIL reset_hi got %h want 0", hi); end
        if (lo !== '0) begin n_errors++; $display("FAIL reset_lo got %h want 0", lo); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        int lat, dones;
        run_op(md_pkg::OP_MULT, 32'hFFFFFFFD, 32'd7, lat, dones);
        n_checks += 4;
        if (lat !== 5) begin n_errors++; $display("FAIL mult_latency got %0d want 5", lat); end
        if (dones !== 1) begin n_errors++; $display("FAIL mult_done got %0d want 1", dones); end
        if (hi !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL mult_hi got %h want FFFFFFFF", hi); end
        if (lo !== 32'hFFFFFFEB) begin n_errors++; $display("FAIL mult_lo got %h want FFFFFFEB", lo); end
        run_op(md_pkg::OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, dones);
        n_checks += 2;
        if (hi !== 32'hFFFFFFFE) begin n_errors++; $display("FAIL multu_hi got %h want FFFFFFFE", hi); end
        if (lo !== 32'h00000001) begin n_errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
    endtask

    task automatic test_div();
        int lat, dones;
        run_op(md_pkg::OP_DIV, 32'hFFFFFFF9, 32'd2, lat, dones);
        n_checks += 4;
        if (lat !== 33) begin n_errors++; $display("FAIL div_latency got %0d want 33", lat); end
        if (dones !== 1) begin n_errors++; $display("FAIL div_done got %0d want 1", dones); end
        if (lo !== 32'hFFFFFFFD) begin n_errors++; $display("FAIL div_lo got %h want FFFFFFFD", lo); end
        if (hi !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL div_hi got %h want FFFFFFFF", hi); end
        run_op(md_pkg::OP_DIVU, 32'd7, 32'd0, lat, dones);
        n_checks += 3;
        if (lat !== 33) begin n_errors++; $display("FAIL divz_latency got %0d want 33", lat); end
        if (hi !== 32'd7) begin n_errors++; $display("FAIL divz_hi got %h want 00000007", hi); end
        if (lo !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL divz_lo got %h want FFFFFFFF", lo); end
        run_op(md_pkg::OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, dones);
        n_checks += 2;
        if (lo !== 32'h80000000) begin n_errors++; $display("FAIL divov_lo got %h want 80000000", lo); end
        if (hi !== 32'h0) begin n_errors++; $display("FAIL divov_hi got %h want 0", hi); end
        run_op(md_pkg::OP_DIV, 32'd7, 32'hFFFFFFFE, lat, dones);
        n_checks += 2;
        if (lo !== 32'hFFFFFFFD) begin n_errors++; $display("FAIL divneg_lo got %h want FFFFFFFD", lo); end
        if (hi !== 32'd1) begin n_errors++; $display("FAIL divneg_hi got %h want 00000001", hi); end
        run_op(md_pkg::OP_DIVU, 32'd100, 32'd7, lat, dones);
        n_checks += 2;
        if (lo !== 32'd14) begin n_errors++; $display("FAIL divu_lo got %h want 0000000E", lo); end
        if (hi !== 32'd2) begin n_errors++; $display("FAIL divu_hi got %h want 00000002", hi); end
    endtask

    task automatic test_mt_mf();
        op = md_pkg::OP_MTHI; a = 32'h1234; start = 1'b0;
        tick();
        op = md_pkg::OP_MTLO; a = 32'h5678;
        tick();
        op = md_pkg::OP_MFHI;
        #1;
        n_checks += 3;
        if (out !== 32'h1234) begin n_errors++; $display("FAIL mfhi_out got %h want 00001234", out); end
        op = md_pkg::OP_MFLO;
        #1;
        if (out !== 32'h5678) begin n_errors++; $display("FAIL mflo_out got %h want 00005678", out); end
        op = md_pkg::OP_MULT;
        #1;
        if (out !== 32'h0) begin n_errors++; $display("FAIL other_out got %h want 0", out); end
    endtask

    task automatic test_flush();
        int dones;
        // flush mid-divide
        op = md_pkg::OP_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks += 4;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL flush_busy got %h want 0", busy); end
        if (hi !== 32'h1234) begin n_errors++; $display("FAIL flush_hi got %h want 00001234", hi); end
        if (lo !== 32'h5678) begin n_errors++; $display("FAIL flush_lo got %h want 00005678", lo); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            tick();
        end
        if (dones !== 0) begin n_errors++; $display("FAIL flush_done got %0d want 0", dones); end
        op = md_pkg::OP_MFHI;
        #1;
        n_checks++;
        if (out !== 32'h1234) begin n_errors++; $display("FAIL flush_mfhi got %h want 00001234", out); end
        // flush on the multiply commit edge
        op = md_pkg::OP_MULT; a = 32'd2; b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        n_checks += 4;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL flushc_prebusy got %h want 1", busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL flushc_busy got %h want 0", busy); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL flushc_done got %h want 0", done); end
        if (lo !== 32'h5678) begin n_errors++; $display("FAIL flushc_lo got %h want 00005678", lo); end
        // flush together with start: nothing launches
        op = md_pkg::OP_MULT; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL flushs_busy got %h want 0", busy); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        op = md_pkg::OP_MULT; a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        op = md_pkg::OP_DIV; a = 32'd9; b = 32'd2;
        tick();
        start = 1'b0; op = md_pkg::OP_MTHI; a = 32'hAAAA;
        tick();
        op = md_pkg::OP_MFLO;
        lat = 0;
        while (busy && lat < 100) begin
            tick();
            lat++;
        end
        n_checks += 4;
        if (lat !== 3) begin n_errors++; $display("FAIL busyign_latency got %0d want 3", lat); end
        if (hi !== 32'h0) begin n_errors++; $display("FAIL busyign_hi got %h want 0", hi); end
        if (lo !== 32'd6) begin n_errors++; $display("FAIL busyign_lo got %h want 00000006", lo); end
        if (out !== 32'd6) begin n_errors++; $display("FAIL busyign_mflo got %h want 00000006", out); end
    endtask

    task automatic test_madd();
        op = md_pkg::OP_MTHI; a = 32'h0;
        tick();
        op = md_pkg::OP_MTLO; a = 32'hFFFFFFFF;
        tick();
`ifdef MD_MADD_EN
        begin
            int lat, dones;
            run_op(md_pkg::OP_MADDU, 32'd1, 32'd1, lat, dones);
            n_checks += 3;
            if (lat !== 5) begin n_errors++; $display("FAIL maddu_latency got %0d want 5", lat); end
            if (hi !== 32'd1) begin n_errors++; $display("FAIL maddu_hi got %h want 00000001", hi); end
            if (lo !== 32'd0) begin n_errors++; $display("FAIL maddu_lo got %h want 0", lo); end
        end
`else
        op = md_pkg::OP_MADDU; a = 32'd1; b = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks += 3;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL maddu_off_busy got %h want 0", busy); end
        if (hi !== 32'h0) begin n_errors++; $display("FAIL maddu_off_hi got %h want 0", hi); end
        if (lo !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL maddu_off_lo got %h want FFFFFFFF", lo); end
`endif
        op = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL unknown_busy got %h want 0", busy); end
    endtask

    task automatic test_reset_mid();
        op = md_pkg::OP_MULT; a = 32'd5; b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        n_checks += 3;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got %h want 0", busy); end
        if (hi !== 32'h0) begin n_errors++; $display("FAIL rstmid_hi got %h want 0", hi); end
        if (lo !== 32'h0) begin n_errors++; $display("FAIL rstmid_lo got %h want 0", lo); end
        reset = 1'b1;
        repeat (6) tick();
        n_checks += 2;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_after_busy got %h want 0", busy); end
        if (lo !== 32'h0) begin n_errors++; $display("FAIL rstmid_after_lo got %h want 0", lo); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        op = 4'd0; a = '0; b = '0;
        test_reset();
        test_mult();
        test_div();
        test_mt_mf();
        test_flush();
        test_busy_ignore();
        test_madd();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
